// File: rtl/sha256_pkg.sv
// Shared SHA-256 job context type exchanged between the host queue,
// the scheduler and the chunk processors.
package sha256_pkg;
  typedef struct packed {
    logic [255:0] h;
    logic [63:0]  msg_len;
    logic [7:0]   job_id;
  } ShaContext;
endpackage

// File: rtl/sha_job_scheduler_if.sv
// Handshake bundle for the job scheduler: host job input, engine context
// dispatch, engine chunk collection and the compression-core chunk output.
interface sha_job_scheduler_if #(
  parameter int NUM_ENGINES = 4
) ();
  import sha256_pkg::*;
  localparam int ENG_W = $clog2(NUM_ENGINES);

  logic                              job_in_rdy;
  logic                              job_in_vld;
  ShaContext                         job_in;
  logic [NUM_ENGINES-1:0]            eng_ctx_rdy;
  logic [NUM_ENGINES-1:0]            eng_ctx_vld;
  ShaContext                         eng_ctx;
  logic [NUM_ENGINES-1:0]            eng_done;
  logic [NUM_ENGINES-1:0]            eng_chunk_vld;
  logic [NUM_ENGINES-1:0]            eng_chunk_rdy;
  logic [NUM_ENGINES-1:0][511:0]     eng_chunk;
  logic                              core_chunk_rdy;
  logic                              core_chunk_vld;
  logic [511:0]                      core_chunk;
  logic [ENG_W-1:0]                  core_chunk_eng;

  modport slave (
    output job_in_rdy, eng_ctx_vld, eng_ctx, eng_chunk_rdy,
           core_chunk_vld, core_chunk, core_chunk_eng,
    input  job_in_vld, job_in, eng_ctx_rdy, eng_done, eng_chunk_vld,
           eng_chunk, core_chunk_rdy
  );

  modport master (
    input  job_in_rdy, eng_ctx_vld, eng_ctx, eng_chunk_rdy,
           core_chunk_vld, core_chunk, core_chunk_eng,
    output job_in_vld, job_in, eng_ctx_rdy, eng_done, eng_chunk_vld,
           eng_chunk, core_chunk_rdy
  );
endinterface

// File: rtl/sha_job_scheduler.sv
// Round-robin dispatch of SHA-256 jobs to free chunk engines, per-engine busy
// tracking, and round-robin arbitration of engine chunks onto the core input.
module sha_job_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sha_job_scheduler_if.slave     bus,
  output logic [NUM_ENGINES-1:0] busy,
  output logic                   idle,
  output logic [CNT_W-1:0]       jobs_dispatched,
  output logic [CNT_W-1:0]       jobs_completed,
  output logic                   err_spurious_done
);
  localparam int ENG_W = $clog2(NUM_ENGINES);

  typedef enum logic [1:0] {EMPTY, HOLD, OFFER} disp_state_e;

  disp_state_e            state_q, state_d;
  ShaContext              hold_q, hold_d;
  logic [ENG_W-1:0]       target_q, target_d;
  logic [ENG_W-1:0]       disp_ptr_q, disp_ptr_d;
  logic [ENG_W-1:0]       chk_ptr_q, chk_ptr_d;
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]       disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0]       comp_cnt_q, comp_cnt_d;
  logic                   err_q, err_d;
  logic                   core_vld_q, core_vld_d;
  logic [511:0]           core_data_q, core_data_d;
  logic [ENG_W-1:0]       core_eng_q, core_eng_d;

  logic                   disp_fire;
  logic [ENG_W:0]         free_pick;
  logic [ENG_W:0]         chunk_pick;
  logic                   load;
  logic [NUM_ENGINES-1:0] done_ok;

  // First set bit of req at or after ptr, wrapping; MSB flags "found".
  function automatic logic [ENG_W:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                             input logic [ENG_W-1:0] ptr);
    logic             found;
    logic [ENG_W-1:0] sel;
    logic [ENG_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      idx = ENG_W'((int'(ptr) + k) % NUM_ENGINES);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [ENG_W-1:0] next_idx(input logic [ENG_W-1:0] i);
    return (int'(i) == NUM_ENGINES - 1) ? '0 : i + ENG_W'(1);
  endfunction

  function automatic logic [NUM_ENGINES-1:0] onehot(input logic [ENG_W-1:0] i);
    logic [NUM_ENGINES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    target_d        = target_q;
    disp_ptr_d      = disp_ptr_q;
    disp_fire       = 1'b0;
    bus.job_in_rdy  = 1'b0;
    bus.eng_ctx_vld = '0;
    free_pick       = rr_pick(~busy_q, disp_ptr_q);
    case (state_q)
      EMPTY: begin
        bus.job_in_rdy = ~rst;
        if (bus.job_in_vld) begin
          hold_d  = bus.job_in;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (free_pick[ENG_W]) begin
          target_d = free_pick[ENG_W-1:0];
          state_d  = OFFER;
        end
      end
      OFFER: begin
        bus.eng_ctx_vld = onehot(target_q);
        if (bus.eng_ctx_rdy[target_q]) begin
          disp_fire  = 1'b1;
          disp_ptr_d = next_idx(target_q);
          state_d    = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A done on a non-busy engine never touches busy or the completion count.
  always_comb begin
    done_ok    = bus.eng_done & busy_q;
    busy_d     = busy_q & ~done_ok;
    if (disp_fire) busy_d = busy_d | onehot(target_q);
    disp_cnt_d = disp_cnt_q + CNT_W'(disp_fire);
    comp_cnt_d = comp_cnt_q + CNT_W'($countones(done_ok));
    err_d      = err_q | (|(bus.eng_done & ~busy_q));
  end

  always_comb begin
    load              = ~core_vld_q | bus.core_chunk_rdy;
    chunk_pick        = rr_pick(bus.eng_chunk_vld, chk_ptr_q);
    bus.eng_chunk_rdy = '0;
    core_vld_d        = core_vld_q;
    core_data_d       = core_data_q;
    core_eng_d        = core_eng_q;
    chk_ptr_d         = chk_ptr_q;
    if (load) begin
      if (chunk_pick[ENG_W]) begin
        bus.eng_chunk_rdy = onehot(chunk_pick[ENG_W-1:0]);
        core_data_d       = bus.eng_chunk[chunk_pick[ENG_W-1:0]];
        core_eng_d        = chunk_pick[ENG_W-1:0];
        core_vld_d        = 1'b1;
        chk_ptr_d         = next_idx(chunk_pick[ENG_W-1:0]);
      end else begin
        core_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q    <= '0;
      disp_ptr_q  <= '0;
      chk_ptr_q   <= '0;
      busy_q      <= '0;
      disp_cnt_q  <= '0;
      comp_cnt_q  <= '0;
      err_q       <= 1'b0;
      core_vld_q  <= 1'b0;
      core_data_q <= '0;
      core_eng_q  <= '0;
    end else begin
      target_q    <= target_d;
      disp_ptr_q  <= disp_ptr_d;
      chk_ptr_q   <= chk_ptr_d;
      busy_q      <= busy_d;
      disp_cnt_q  <= disp_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      err_q       <= err_d;
      core_vld_q  <= core_vld_d;
      core_data_q <= core_data_d;
      core_eng_q  <= core_eng_d;
    end
  end

  // The held context is only observed while OFFER is active, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.eng_ctx        = hold_q;
  assign bus.core_chunk_vld = core_vld_q;
  assign bus.core_chunk     = core_data_q;
  assign bus.core_chunk_eng = core_eng_q;
  assign busy               = busy_q;
  assign idle               = (state_q == EMPTY) & ~(|busy_q) & ~core_vld_q;
  assign jobs_dispatched    = disp_cnt_q;
  assign jobs_completed     = comp_cnt_q;
  assign err_spurious_done  = err_q;
endmodule

// File: tb/tb_sha_job_scheduler.sv
// Directed bench for sha_job_scheduler: dispatch/busy table plus sequences
// for chunk arbitration, back-pressure, spurious done and mid-operation reset.
module tb_sha_job_scheduler;
  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  busy;
  logic        idle;
  logic [15:0] jobs_dispatched;
  logic [15:0] jobs_completed;
  logic        err_spurious_done;

  int nvec = 0;
  int nmis = 0;

  sha_job_scheduler_if #(.NUM_ENGINES(4)) bus ();

  sha_job_scheduler #(.NUM_ENGINES(4), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .busy              (busy),
    .idle              (idle),
    .jobs_dispatched   (jobs_dispatched),
    .jobs_completed    (jobs_completed),
    .err_spurious_done (err_spurious_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jv;
    logic [15:0] len;
    logic [3:0]  crdy;
    logic [3:0]  done;
    logic        e_rdy;
    logic [3:0]  e_vld;
    logic [15:0] e_len;
    logic [3:0]  e_busy;
    logic [15:0] e_disp;
    logic [15:0] e_comp;
    logic        e_err;
  } vec_t;

  vec_t         tbl[26];
  logic [511:0] cdata[4];
  int           seq[3];

  function automatic vec_t mk(logic jv, logic [15:0] len, logic [3:0] crdy, logic [3:0] done,
                              logic e_rdy, logic [3:0] e_vld, logic [15:0] e_len,
                              logic [3:0] e_busy, logic [15:0] e_disp, logic [15:0] e_comp,
                              logic e_err);
    vec_t v;
    v.jv = jv; v.len = len; v.crdy = crdy; v.done = done;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_len = e_len; v.e_busy = e_busy;
    v.e_disp = e_disp; v.e_comp = e_comp; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.job_in_vld     = 1'b0;
    bus.eng_ctx_rdy    = '0;
    bus.eng_done       = '0;
    bus.eng_chunk_vld  = '0;
    bus.core_chunk_rdy = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("job_in_rdy during rst", bus.job_in_rdy, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset outputs",
        {bus.job_in_rdy, bus.eng_ctx_vld, bus.eng_chunk_rdy, bus.core_chunk_vld,
         bus.core_chunk_eng, busy, idle, jobs_dispatched, jobs_completed, err_spurious_done},
        {1'b1, 4'b0, 4'b0, 1'b0, 2'b0, 4'b0, 1'b1, 16'd0, 16'd0, 1'b0});
    chk("reset core_chunk", bus.core_chunk, '0);
    tick();
  endtask

  task automatic send_job(input logic [15:0] len);
    bit ok;
    ok = 1'b0;
    bus.job_in         = '0;
    bus.job_in.msg_len = 64'(len);
    bus.job_in_vld     = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (bus.job_in_rdy) ok = 1'b1;
      tick();
    end
    bus.job_in_vld = 1'b0;
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL send_job timeout: job_in_rdy never seen, wanted 1");
    end
  endtask

  task automatic wait_ctx(output logic [3:0] v);
    v = '0;
    for (int n = 0; n < 20 && v == 4'b0; n++) begin
      @(negedge clk);
      if (bus.eng_ctx_vld != 4'b0) v = bus.eng_ctx_vld;
      else tick();
    end
    if (v == 4'b0) begin
      nvec++;
      nmis++;
      $display("FAIL wait_ctx timeout: eng_ctx_vld stayed 0, wanted nonzero");
    end
  endtask

  initial begin
    logic [3:0] v;
    logic [15:0] act_len;

    for (int i = 0; i < 4; i++) begin
      cdata[i]         = {64{8'(8'hA0 + i)}};
      bus.eng_chunk[i] = cdata[i];
    end
    seq[0] = 0; seq[1] = 1; seq[2] = 3;
    bus.job_in = '0;

    //            jv len  crdy done  rdy vld len  busy disp comp err
    tbl[0]  = mk(1, 64,  4'hF, 4'h0, 1, 4'h0, 0,   4'h0, 0, 0, 0);
    tbl[1]  = mk(1, 100, 4'hF, 4'h0, 0, 4'h0, 0,   4'h0, 0, 0, 0);
    tbl[2]  = mk(1, 100, 4'hF, 4'h0, 0, 4'h1, 64,  4'h0, 0, 0, 0);
    tbl[3]  = mk(1, 100, 4'hF, 4'h0, 1, 4'h0, 0,   4'h1, 1, 0, 0);
    tbl[4]  = mk(1, 0,   4'hF, 4'h0, 0, 4'h0, 0,   4'h1, 1, 0, 0);
    tbl[5]  = mk(1, 0,   4'hF, 4'h0, 0, 4'h2, 100, 4'h1, 1, 0, 0);
    tbl[6]  = mk(1, 0,   4'hF, 4'h0, 1, 4'h0, 0,   4'h3, 2, 0, 0);
    tbl[7]  = mk(1, 447, 4'hF, 4'h0, 0, 4'h0, 0,   4'h3, 2, 0, 0);
    tbl[8]  = mk(1, 447, 4'hF, 4'h0, 0, 4'h4, 0,   4'h3, 2, 0, 0);
    tbl[9]  = mk(1, 447, 4'hF, 4'h0, 1, 4'h0, 0,   4'h7, 3, 0, 0);
    tbl[10] = mk(1, 5,   4'hF, 4'h0, 0, 4'h0, 0,   4'h7, 3, 0, 0);
    tbl[11] = mk(1, 5,   4'hF, 4'h0, 0, 4'h8, 447, 4'h7, 3, 0, 0);
    tbl[12] = mk(1, 5,   4'hF, 4'h0, 1, 4'h0, 0,   4'hF, 4, 0, 0);
    tbl[13] = mk(0, 0,   4'hF, 4'h0, 0, 4'h0, 0,   4'hF, 4, 0, 0);
    tbl[14] = mk(0, 0,   4'hF, 4'h0, 0, 4'h0, 0,   4'hF, 4, 0, 0);
    tbl[15] = mk(0, 0,   4'hF, 4'h4, 0, 4'h0, 0,   4'hF, 4, 0, 0);
    tbl[16] = mk(0, 0,   4'hF, 4'h0, 0, 4'h0, 0,   4'hB, 4, 1, 0);
    tbl[17] = mk(0, 0,   4'hF, 4'h0, 0, 4'h4, 5,   4'hB, 4, 1, 0);
    tbl[18] = mk(0, 0,   4'hF, 4'h0, 1, 4'h0, 0,   4'hF, 5, 1, 0);
    tbl[19] = mk(0, 0,   4'hF, 4'h9, 1, 4'h0, 0,   4'hF, 5, 1, 0);
    tbl[20] = mk(1, 7,   4'hF, 4'h0, 1, 4'h0, 0,   4'h6, 5, 3, 0);
    tbl[21] = mk(0, 0,   4'hF, 4'h0, 0, 4'h0, 0,   4'h6, 5, 3, 0);
    tbl[22] = mk(0, 0,   4'h7, 4'h0, 0, 4'h8, 7,   4'h6, 5, 3, 0);
    tbl[23] = mk(0, 0,   4'hF, 4'h0, 0, 4'h8, 7,   4'h6, 5, 3, 0);
    tbl[24] = mk(0, 0,   4'hF, 4'h1, 1, 4'h0, 0,   4'hE, 6, 3, 0);
    tbl[25] = mk(0, 0,   4'hF, 4'h0, 1, 4'h0, 0,   4'hE, 6, 3, 1);

    do_reset();

    // Dispatch, busy tracking and completion accounting, one row per cycle.
    for (int i = 0; i < 26; i++) begin
      bus.job_in_vld     = tbl[i].jv;
      bus.job_in         = '0;
      bus.job_in.msg_len = 64'(tbl[i].len);
      bus.eng_ctx_rdy    = tbl[i].crdy;
      bus.eng_done       = tbl[i].done;
      @(negedge clk);
      act_len = (bus.eng_ctx_vld != 4'b0) ? bus.eng_ctx.msg_len[15:0] : 16'd0;
      chk($sformatf("dispatch row %0d", i),
          {bus.job_in_rdy, bus.eng_ctx_vld, act_len, busy, jobs_dispatched, jobs_completed,
           err_spurious_done},
          {tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_len, tbl[i].e_busy, tbl[i].e_disp,
           tbl[i].e_comp, tbl[i].e_err});
      tick();
    end
    bus.job_in_vld = 1'b0;
    bus.eng_done   = '0;

    // Chunk arbitration with engines 0,1,3 requesting continuously.
    do_reset();
    bus.eng_chunk_vld  = 4'b1011;
    bus.core_chunk_rdy = 1'b1;
    @(negedge clk);
    chk("chunk first grant", {bus.core_chunk_vld, bus.eng_chunk_rdy}, {1'b0, 4'b0001});
    tick();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr step %0d", k),
          {bus.core_chunk_vld, bus.core_chunk_eng, bus.eng_chunk_rdy},
          {1'b1, 2'(seq[(k-1)%3]), oh(seq[k%3])});
      chk($sformatf("rr data %0d", k), bus.core_chunk, cdata[seq[(k-1)%3]]);
      tick();
    end
    bus.core_chunk_rdy = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("stall step %0d", k),
          {bus.core_chunk_vld, bus.core_chunk_eng, bus.eng_chunk_rdy}, {1'b1, 2'd0, 4'b0000});
      chk($sformatf("stall data %0d", k), bus.core_chunk, cdata[0]);
      tick();
    end
    bus.core_chunk_rdy = 1'b1;
    @(negedge clk);
    chk("release grant", {bus.core_chunk_vld, bus.core_chunk_eng, bus.eng_chunk_rdy},
        {1'b1, 2'd0, 4'b0010});
    tick();
    @(negedge clk);
    chk("release next", {bus.core_chunk_vld, bus.core_chunk_eng, bus.eng_chunk_rdy},
        {1'b1, 2'd1, 4'b1000});
    chk("release data", bus.core_chunk, cdata[1]);
    tick();
    bus.eng_chunk_vld = 4'b0000;
    @(negedge clk);
    chk("drain last", {bus.core_chunk_vld, bus.core_chunk_eng, bus.eng_chunk_rdy},
        {1'b1, 2'd3, 4'b0000});
    tick();
    @(negedge clk);
    chk("drain empty", bus.core_chunk_vld, 1'b0);
    tick();

    // Spurious done on an idle engine.
    bus.eng_done = 4'b0010;
    @(negedge clk);
    chk("err before spurious", err_spurious_done, 1'b0);
    tick();
    bus.eng_done = 4'b0000;
    @(negedge clk);
    chk("spurious done", {err_spurious_done, busy, jobs_completed}, {1'b1, 4'b0, 16'd0});
    tick();
    tick();
    @(negedge clk);
    chk("spurious sticky", {err_spurious_done, busy, jobs_completed}, {1'b1, 4'b0, 16'd0});
    tick();

    // Reset while a job is offered and a chunk is pending.
    do_reset();
    bus.eng_ctx_rdy = 4'hF;
    send_job(16'd11);
    wait_ctx(v);
    chk("pre-reset first target", v, 4'b0001);
    tick();
    @(negedge clk);
    chk("pre-reset busy", {busy, jobs_dispatched}, {4'b0001, 16'd1});
    tick();
    bus.eng_chunk_vld  = 4'b0001;
    bus.core_chunk_rdy = 1'b1;
    tick();
    bus.eng_chunk_vld  = 4'b0010;
    bus.core_chunk_rdy = 1'b0;
    bus.eng_ctx_rdy    = 4'h0;
    send_job(16'd22);
    wait_ctx(v);
    chk("pre-reset offer target", v, 4'b0010);
    chk("pre-reset chunk pending", {bus.core_chunk_vld, bus.eng_chunk_rdy}, {1'b1, 4'b0000});
    tick();
    do_reset();
    bus.eng_ctx_rdy = 4'hF;
    send_job(16'd33);
    wait_ctx(v);
    chk("post-reset target", v, 4'b0001);
    chk("post-reset ctx", bus.eng_ctx.msg_len, 64'd33);
    tick();
    bus.eng_chunk_vld  = 4'b0011;
    bus.core_chunk_rdy = 1'b1;
    @(negedge clk);
    chk("post-reset chunk grant", bus.eng_chunk_rdy, 4'b0001);
    tick();
    @(negedge clk);
    chk("post-reset chunk data", {bus.core_chunk_eng, bus.core_chunk}, {2'd0, cdata[0]});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/sha_job_scheduler.md
Name: sha_job_scheduler

Overview:
- Sits between the host-side job queue and a bank of NUM_ENGINES chunk processors.
- Dispatches incoming SHA-256 contexts (sha256_pkg::ShaContext) to free engines in round-robin order and tracks per-engine busy state.
- Arbitrates the engines' 512-bit chunk outputs onto the single compression-core input, tagging each chunk with its source engine.

Parameters:
- NUM_ENGINES, 4, number of chunk processors served (2..8)
- ENG_W, $clog2(NUM_ENGINES), engine index width (derived, not overridable)
- CNT_W, 16, width of job statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- job_in_rdy  out  1  scheduler can accept a job
- job_in_vld  in  1  job valid
- job_in  in  ShaContext  job context
- eng_ctx_rdy  in  NUM_ENGINES  per-engine ctx_in_rdy
- eng_ctx_vld  out  NUM_ENGINES  per-engine ctx_in_vld (one-hot or zero)
- eng_ctx  out  ShaContext  context broadcast to all engines
- eng_done  in  NUM_ENGINES  one-cycle pulse when an engine finishes its job
- eng_chunk_vld  in  NUM_ENGINES  per-engine chunk_out_vld
- eng_chunk_rdy  out  NUM_ENGINES  per-engine chunk_out_rdy (one-hot or zero)
- eng_chunk  in  NUM_ENGINES x 512  per-engine chunk_out
- core_chunk_rdy  in  1  compression core ready
- core_chunk_vld  out  1  chunk valid to core
- core_chunk  out  512  chunk data
- core_chunk_eng  out  ENG_W  source engine of core_chunk
- busy  out  NUM_ENGINES  per-engine busy flags
- idle  out  1  no job held and no engine busy
- jobs_dispatched  out  CNT_W  wrapping dispatch count
- jobs_completed  out  CNT_W  wrapping completion count
- err_spurious_done  out  1  sticky: eng_done seen on a non-busy engine

Behaviour:
- Reset values: job_in_rdy=0 during rst, 1 on the first cycle after. All other outputs reset to 0: eng_ctx_vld, eng_chunk_rdy, core_chunk_vld, core_chunk, core_chunk_eng, busy, counters, err. idle=1.
- Reset mid-operation: all state is discarded. Held jobs and in-flight chunks are dropped, and both round-robin pointers return to 0.
- Dispatch FSM, states EMPTY, HOLD, OFFER:
  - EMPTY: job_in_rdy=1. On job_in_vld, latch job_in into the hold register and go to HOLD.
  - HOLD: job_in_rdy=0. If any engine has busy=0, select the first free engine at or after disp_ptr (modulo NUM_ENGINES), register it as target, and go to OFFER. Otherwise stay in HOLD.
  - OFFER: eng_ctx_vld[target]=1, eng_ctx=hold register. target and eng_ctx stay stable until the handshake. On eng_ctx_rdy[target], set busy[target], set disp_ptr=target+1 (wrapping), increment jobs_dispatched, and go to EMPTY. eng_ctx_vld drops the next cycle.
- Dispatch latency:
  - job_in handshake at cycle T gives the earliest eng_ctx_vld at T+2.
  - Minimum job-to-job spacing is 3 cycles.
- Busy tracking:
  - eng_done[i] with busy[i]=1 clears busy[i] and increments jobs_completed.
  - eng_done[i] with busy[i]=0 is ignored and sets err_spurious_done; the flag clears only on rst.
  - Multiple eng_done bits in one cycle: jobs_completed adds the popcount of valid dones.
  - A dispatch handshake and a done on different engines in the same cycle are both applied.
- Chunk arbiter, registered output stage:
  - load = ~core_chunk_vld | core_chunk_rdy.
  - When load is 1 and any eng_chunk_vld is set, grant the first requester at or after chk_ptr. Drive eng_chunk_rdy[grant]=1 combinationally, capture eng_chunk[grant] into core_chunk and grant into core_chunk_eng, set core_chunk_vld=1, and set chk_ptr=grant+1.
  - When load is 1 and there are no requests, core_chunk_vld goes to 0.
  - When load is 0, eng_chunk_rdy is all 0 and the outputs hold.
  - Throughput: 1 chunk/cycle while core_chunk_rdy=1. Latency: 1 cycle from grant to core_chunk_vld.
  - No engine is starved: every requester is served within NUM_ENGINES grants.
- idle = (FSM==EMPTY) & ~|busy & ~core_chunk_vld.
- Counters wrap at 2^CNT_W with no saturation.

Test Plan:
- Reset, then 4 back-to-back jobs (length 64,100,0,447) with all engines ready -> dispatched to engines 0,1,2,3 in order; busy=4'b1111; jobs_dispatched=4; job 5 stays in HOLD with job_in_rdy=0.
- With all engines busy, pulse eng_done[2] -> job 5 goes to engine 2 within 2 cycles; jobs_completed=1; disp_ptr=3.
- Engines 0,1,3 assert eng_chunk_vld continuously, core_chunk_rdy=1 -> core_chunk_eng sequence 0,1,3,0,1,3; each chunk matches its source data.
- Hold core_chunk_rdy=0 for 5 cycles while chunks are pending -> core_chunk and core_chunk_eng stable, eng_chunk_rdy=0 throughout; on release, resumes at the next round-robin engine.
- eng_done[1] on an idle engine -> err_spurious_done=1 and stays 1; jobs_completed unchanged; busy unchanged.
- Assert rst during OFFER with a chunk pending -> next cycle all outputs at reset values, idle=1; a new job then dispatches to engine 0.
